vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 14 +
 rtl/vram_arbiter_if.sv | 47 ++++
 rtl/vram_rd_tag_pipe.sv | 27 ++
 rtl/vram_arbiter.sv | 138 +++++++++++++
 tb/tb_vram_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM constants and the read-return owner tag used by the arbiter.
package vram_pkg;

    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 32;
    localparam int VRAM_RD_LAT = 2;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CPU
    } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and VRAM-port signals of the arbiter; slave is the arbiter side.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
);
    logic                  disp_req;
    logic [ADDR_W-1:0]     disp_addr;
    logic                  disp_gnt;
    logic                  disp_rvalid;
    logic [DATA_W-1:0]     disp_rdata;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W/8-1:0]   cpu_wstrb;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_W-1:0]     cpu_rdata;

    logic                  mem_en;
    logic [DATA_W/8-1:0]   mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/vram_rd_tag_pipe.sv
// Owner-tag delay line: tags each granted read so its data returns to the right requester.
module vram_rd_tag_pipe
    import vram_pkg::*;
#(
    parameter int DEPTH = VRAM_RD_LAT
) (
    input  logic   S_AXI_ACLK,
    input  logic   S_AXI_ARESET,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t stages [DEPTH];

    // NOTE: every stage is cleared on reset (flip-flops, not RAM) so reads granted before reset never return.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= OWN_NONE;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter: display has priority, CPU is forced through after MAX_WAIT denials.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int RD_LAT   = VRAM_RD_LAT,
    parameter int MAX_WAIT = 4
) (
    input logic           S_AXI_ACLK,
    input logic           S_AXI_ARESET,
    vram_arbiter_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_state_t;

    arb_state_t          state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic                disp_gnt;
    logic                cpu_gnt;
    owner_t              rd_owner;
    owner_t              ret_owner;

    logic                mem_en_q;
    logic [STRB_W-1:0]   mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                disp_rvalid_q;
    logic                cpu_rvalid_q;
    logic [DATA_W-1:0]   disp_rdata_q;
    logic [DATA_W-1:0]   cpu_rdata_q;

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        disp_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (!S_AXI_ARESET) begin
            if (state == ARB_FORCE) begin
                cpu_gnt  = bus.cpu_req;
                disp_gnt = bus.disp_req & ~bus.cpu_req;
            end else begin
                disp_gnt = bus.disp_req;
                cpu_gnt  = bus.cpu_req & ~bus.disp_req;
            end
        end
    end

    always_comb begin
        wait_next = '0;
        if (bus.cpu_req && !cpu_gnt) begin
            if (wait_cnt == WAIT_W'(MAX_WAIT)) wait_next = wait_cnt;
            else                               wait_next = wait_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_owner = OWN_NONE;
        if (cpu_gnt && !bus.cpu_we) rd_owner = OWN_CPU;
        else if (disp_gnt)          rd_owner = OWN_DISP;
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state    <= ARB_NORMAL;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_next;
            case (state)
                ARB_NORMAL: if (wait_next == WAIT_W'(MAX_WAIT)) state <= ARB_FORCE;
                ARB_FORCE:  if (cpu_gnt || !bus.cpu_req)         state <= ARB_NORMAL;
                default:    state <= ARB_NORMAL;
            endcase
        end
    end

    // The VRAM port is driven from registers, one cycle after the grant.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q <= disp_gnt | cpu_gnt;
            if (cpu_gnt) begin
                mem_addr_q  <= bus.cpu_addr;
                mem_we_q    <= bus.cpu_we ? bus.cpu_wstrb : '0;
                mem_wdata_q <= bus.cpu_we ? bus.cpu_wdata : '0;
            end else if (disp_gnt) begin
                mem_addr_q  <= bus.disp_addr;
                mem_we_q    <= '0;
                mem_wdata_q <= '0;
            end else begin
                mem_addr_q  <= '0;
                mem_we_q    <= '0;
                mem_wdata_q <= '0;
            end
        end
    end

    vram_rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .tag_in       (rd_owner),
        .tag_out      (ret_owner)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            disp_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            disp_rdata_q  <= '0;
            cpu_rdata_q   <= '0;
        end else begin
            disp_rvalid_q <= (ret_owner == OWN_DISP);
            cpu_rvalid_q  <= (ret_owner == OWN_CPU);
            if (ret_owner == OWN_DISP) disp_rdata_q <= bus.mem_rdata;
            if (ret_owner == OWN_CPU)  cpu_rdata_q  <= bus.mem_rdata;
        end
    end

    assign bus.disp_gnt    = disp_gnt;
    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.cpu_rvalid  = cpu_rvalid_q;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.cpu_rdata   = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter; the memory model answers RD_LAT-1 cycles after mem_en.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rv_cnt   = 0;
    logic [DATA_W-1:0] mem_q = '0;

    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .MAX_WAIT(4)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus)
    );

    function automatic logic [DATA_W-1:0] model(input logic [ADDR_W-1:0] a);
        return (a == 11'h010) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(a));
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we == '0) mem_q <= model(bus.mem_addr);
    end
    assign bus.mem_rdata = mem_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_wstrb = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},      64'(bus.mem_en), 64'(0));
        check({tag, "_mem_we"},      64'(bus.mem_we), 64'(0));
        check({tag, "_mem_addr"},    64'(bus.mem_addr), 64'(0));
        check({tag, "_mem_wdata"},   64'(bus.mem_wdata), 64'(0));
        check({tag, "_disp_rvalid"}, 64'(bus.disp_rvalid), 64'(0));
        check({tag, "_cpu_rvalid"},  64'(bus.cpu_rvalid), 64'(0));
        check({tag, "_disp_rdata"},  64'(bus.disp_rdata), 64'(0));
        check({tag, "_cpu_rdata"},   64'(bus.cpu_rdata), 64'(0));
        check({tag, "_gnts"},        64'({bus.disp_gnt, bus.cpu_gnt}), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset cycle with both requests high: no grant may be issued.
        rst = 1'b1;
        idle_inputs();
        bus.disp_req = 1'b1;
        bus.cpu_req  = 1'b1;
        sample();
        check("rst_no_gnt", 64'({bus.disp_gnt, bus.cpu_gnt}), 64'(0));
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        sample();
        check_all_zero("post_rst");
        next_cycle();

        // Lone CPU read; wdata is junk and must not reach the VRAM port.
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 11'h010;
        bus.cpu_wdata = 32'hFFFF_FFFF;
        sample();
        check("a_cpu_gnt", 64'(bus.cpu_gnt), 64'(1));
        check("a_disp_gnt", 64'(bus.disp_gnt), 64'(0));
        next_cycle();
        idle_inputs();
        sample();
        check("a_mem_en", 64'(bus.mem_en), 64'(1));
        check("a_mem_addr", 64'(bus.mem_addr), 64'(11'h010));
        check("a_mem_we", 64'(bus.mem_we), 64'(0));
        check("a_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        next_cycle();
        sample();
        check("a_rvalid_early", 64'(bus.cpu_rvalid), 64'(0));
        next_cycle();
        sample();
        check("a_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(1));
        check("a_cpu_rdata", 64'(bus.cpu_rdata), 64'(32'hDEADBEEF));
        check("a_disp_rvalid", 64'(bus.disp_rvalid), 64'(0));
        next_cycle();
        sample();
        check("a_rvalid_pulse", 64'(bus.cpu_rvalid), 64'(0));
        check("a_rdata_hold", 64'(bus.cpu_rdata), 64'(32'hDEADBEEF));
        next_cycle();

        // Simultaneous requests: display first, CPU next cycle, returns in order.
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h100;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 11'h020;
        sample();
        check("b_disp_gnt", 64'(bus.disp_gnt), 64'(1));
        check("b_cpu_wait", 64'(bus.cpu_gnt), 64'(0));
        next_cycle();
        bus.disp_req = 1'b0;
        sample();
        check("b_cpu_gnt", 64'(bus.cpu_gnt), 64'(1));
        check("b_mem_addr0", 64'(bus.mem_addr), 64'(11'h100));
        next_cycle();
        idle_inputs();
        sample();
        check("b_mem_addr1", 64'(bus.mem_addr), 64'(11'h020));
        next_cycle();
        sample();
        check("b_disp_rvalid", 64'(bus.disp_rvalid), 64'(1));
        check("b_disp_rdata", 64'(bus.disp_rdata), 64'(model(11'h100)));
        check("b_cpu_not_yet", 64'(bus.cpu_rvalid), 64'(0));
        next_cycle();
        sample();
        check("b_cpu_rvalid", 64'(bus.cpu_rvalid), 64'(1));
        check("b_cpu_rdata", 64'(bus.cpu_rdata), 64'(model(11'h020)));
        check("b_disp_done", 64'(bus.disp_rvalid), 64'(0));
        next_cycle();

        // Display hogs the port; CPU must be forced through on its 5th waiting cycle.
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h200;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 11'h030;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("c_disp_wins", 64'({bus.disp_gnt, bus.cpu_gnt}), 64'(2'b10));
            next_cycle();
        end
        sample();
        check("c_forced_cpu", 64'({bus.disp_gnt, bus.cpu_gnt}), 64'(2'b01));
        next_cycle();
        bus.cpu_req = 1'b0;
        sample();
        check("c_disp_resume", 64'({bus.disp_gnt, bus.cpu_gnt}), 64'(2'b10));
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) next_cycle();

        // Byte-masked write, then a write with no strobes.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h258;
        bus.cpu_wdata = 32'h0041_0041;
        bus.cpu_wstrb = 4'b0011;
        sample();
        check("d_wr_gnt", 64'(bus.cpu_gnt), 64'(1));
        next_cycle();
        idle_inputs();
        sample();
        check("d_mem_en", 64'(bus.mem_en), 64'(1));
        check("d_mem_we", 64'(bus.mem_we), 64'(4'b0011));
        check("d_mem_addr", 64'(bus.mem_addr), 64'(11'h258));
        check("d_mem_wdata", 64'(bus.mem_wdata), 64'(32'h0041_0041));
        next_cycle();
        sample();
        check("d_idle_en", 64'(bus.mem_en), 64'(0));
        check("d_idle_wdata", 64'(bus.mem_wdata), 64'(0));
        next_cycle();
        sample();
        check("d_no_rvalid", 64'({bus.disp_rvalid, bus.cpu_rvalid}), 64'(0));
        next_cycle();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h259;
        bus.cpu_wdata = 32'h1234_5678;
        bus.cpu_wstrb = 4'b0000;
        sample();
        check("d0_gnt", 64'(bus.cpu_gnt), 64'(1));
        next_cycle();
        idle_inputs();
        sample();
        check("d0_mem_en", 64'(bus.mem_en), 64'(1));
        check("d0_mem_we", 64'(bus.mem_we), 64'(0));
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            check("d0_no_rvalid", 64'({bus.disp_rvalid, bus.cpu_rvalid}), 64'(0));
        end
        next_cycle();

        // Reset one cycle after a CPU read grant flushes the read.
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 11'h040;
        sample();
        check("e_gnt", 64'(bus.cpu_gnt), 64'(1));
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        sample();
        check("e_mem_en_pre", 64'(bus.mem_en), 64'(1));
        next_cycle();
        rst = 1'b0;
        sample();
        check_all_zero("e_flush");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("e_no_rvalid", 64'(bus.cpu_rvalid), 64'(0));
        end
        next_cycle();

        // Alternating display/CPU reads every cycle: 16 in-order returns, no gaps.
        for (int i = 0; i < 19; i++) begin
            idle_inputs();
            if (i < 16) begin
                if (i % 2 == 0) begin
                    bus.disp_req  = 1'b1;
                    bus.disp_addr = ADDR_W'(32'h300 + i);
                end else begin
                    bus.cpu_req  = 1'b1;
                    bus.cpu_addr = ADDR_W'(32'h400 + i);
                end
            end
            sample();
            if (i < 16) begin
                check("f_disp_gnt", 64'(bus.disp_gnt), 64'(i % 2 == 0));
                check("f_cpu_gnt", 64'(bus.cpu_gnt), 64'(i % 2 == 1));
            end
            if (i < 3) begin
                check("f_no_early_rvalid", 64'({bus.disp_rvalid, bus.cpu_rvalid}), 64'(0));
            end else if ((i - 3) % 2 == 0) begin
                check("f_disp_rvalid", 64'({bus.disp_rvalid, bus.cpu_rvalid}), 64'(2'b10));
                check("f_disp_rdata", 64'(bus.disp_rdata), 64'(model(ADDR_W'(32'h300 + i - 3))));
            end else begin
                check("f_cpu_rvalid", 64'({bus.disp_rvalid, bus.cpu_rvalid}), 64'(2'b01));
                check("f_cpu_rdata", 64'(bus.cpu_rdata), 64'(model(ADDR_W'(32'h400 + i - 3))));
            end
            if (bus.disp_rvalid || bus.cpu_rvalid) rv_cnt++;
            next_cycle();
        end
        check("f_rvalid_count", 64'(rv_cnt), 64'(16));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
